sram512_fifo_ctrl: RTL and testbench

Sequencing controller that turns the 512x8 dual-port synchronous SRAM (sram512) into a 512-entry byte FIFO.
- Port A of the SRAM is write-only.
- Port B of the SRAM is read-only.
- The block owns both pointers, the occupancy count, the status flags and the read-data valid strobe.
- It sits between a byte producer and a byte consumer, e.g. the MSX bus side and the FPGA-side bridge logic, in front of an externally instantiated sram512.

---
 rtl/sram512_fifo_ctrl.sv | 89 ++++++++
 tb/tb_sram512_fifo_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram512_fifo_ctrl.sv
// Byte FIFO sequencer for an external 512x8 dual-port synchronous SRAM.
// Port A writes at wr_ptr, port B reads at rd_ptr; read data arrives one cycle after an accepted pop.
module sram512_fifo_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 8,
  parameter int AFULL_LEVEL  = 448,
  parameter int AEMPTY_LEVEL = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  output logic              mem_reb,
  output logic [ADDR_W-1:0] mem_addrb,
  input  logic [DATA_W-1:0] mem_doutb
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_W:0] AEMPTY_CNT = (ADDR_W + 1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              clear;
  logic              pop_acc;
  logic              push_acc;

  assign clear = ~reset_n | flush;

  // A push into a full FIFO is legal only alongside an accepted pop; the
  // SRAM is read-before-write, so the shared address returns the old byte.
  assign pop_acc  = pop & ~empty & ~clear;
  assign push_acc = push & (~full | pop_acc) & ~clear;

  assign mem_wea   = push_acc;
  assign mem_addra = wr_ptr;
  assign mem_dina  = push_data;
  assign mem_reb   = pop_acc;
  assign mem_addrb = rd_ptr;
  assign pop_data  = mem_doutb;

  // Status flags come from the registered count, so they lag the operation by one cycle.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      pop_valid <= pop_acc;
      if (push & ~push_acc) overflow  <= 1'b1;
      if (pop & ~pop_acc)   underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram512_fifo_ctrl.sv
// Self-checking bench for sram512_fifo_ctrl with a behavioural read-before-write SRAM.
// A queue model predicts every read byte; a monitor compares pop_valid/pop_data each cycle.
module tb_sram512_fifo_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              push = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [ADDR_W:0]   count;
  logic              full, empty, almost_full, almost_empty;
  logic              overflow, underflow;
  logic              mem_wea, mem_reb;
  logic [ADDR_W-1:0] mem_addra, mem_addrb;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_doutb;

  always #5 clk = ~clk;

  // Dual-port SRAM: registered read sees the pre-write contents on a shared address.
  logic [DATA_W-1:0] sram [512];
  always @(posedge clk) begin
    if (mem_reb) mem_doutb <= sram[mem_addrb];
    if (mem_wea) sram[mem_addra] <= mem_dina;
  end

  sram512_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AFULL_LEVEL(448), .AEMPTY_LEVEL(64)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_reb(mem_reb),
    .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [DATA_W-1:0] m_fifo [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_b;
  bit exp_vld_d = 1'b0;
  bit exp_vld = 1'b0;
  bit mon_en = 1'b0;

  always @(posedge clk) exp_vld <= exp_vld_d;

  // Scoreboard comparator: pop_valid must follow each accepted pop by one cycle.
  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      n_total++;
      if (pop_valid !== exp_vld) $display("FAIL pop_valid: got %b expected %b at %0t", pop_valid, exp_vld, $time);
      else n_pass++;
      if (exp_vld) begin
        exp_b = exp_q.pop_front();
        if (pop_valid === 1'b1) begin
          n_total++;
          if (pop_data !== exp_b) $display("FAIL pop_data: got %02h expected %02h at %0t", pop_data, exp_b, $time);
          else n_pass++;
        end
      end
    end
  end

  // Drive one cycle of stimulus and advance the reference model accordingly.
  task automatic step(input bit ps, input logic [DATA_W-1:0] d, input bit pp, input bit fl);
    bit pop_ok, push_ok;
    push = ps; push_data = d; pop = pp; flush = fl;
    pop_ok  = pp && (m_fifo.size() != 0) && !fl && (reset_n === 1'b1);
    push_ok = ps && ((m_fifo.size() < 512) || pop_ok) && !fl && (reset_n === 1'b1);
    if (fl || reset_n !== 1'b1) m_fifo.delete();
    if (pop_ok) exp_q.push_back(m_fifo.pop_front());
    if (push_ok) m_fifo.push_back(d);
    exp_vld_d = pop_ok;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; push = 1'b1; pop = 1'b1; push_data = 8'h5A; exp_vld_d = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_total++; if (mem_wea !== 1'b0) $display("FAIL reset_wea: got %b expected 0", mem_wea); else n_pass++;
      n_total++; if (mem_reb !== 1'b0) $display("FAIL reset_reb: got %b expected 0", mem_reb); else n_pass++;
      @(posedge clk);
    end
    #1;
    reset_n = 1'b1;
    m_fifo.delete();
    mon_en = 1'b1;
    step(0, 8'h00, 0, 0);
    n_total++; if (count !== 10'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
    n_total++; if (almost_empty !== 1'b1) $display("FAIL reset_aempty: got %b expected 1", almost_empty); else n_pass++;
    n_total++; if (almost_full !== 1'b0) $display("FAIL reset_afull: got %b expected 0", almost_full); else n_pass++;
    n_total++; if (pop_valid !== 1'b0) $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else n_pass++;
  endtask

  task automatic test_push_pop();
    logic [DATA_W-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    foreach (vals[i]) step(1, vals[i], 0, 0);
    n_total++; if (count !== 10'd3) $display("FAIL pp_count_full: got %0d expected 3", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      n_total++; if (count !== 10'(2 - i)) $display("FAIL pp_count_drain: got %0d expected %0d", count, 2 - i); else n_pass++;
    end
    step(0, 8'h00, 0, 0);
    n_total++; if (empty !== 1'b1) $display("FAIL pp_empty: got %b expected 1", empty); else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 512; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 446) begin
        n_total++; if (almost_full !== 1'b0) $display("FAIL fd_afull_447: got %b expected 0", almost_full); else n_pass++;
      end
      if (i == 447) begin
        n_total++; if (almost_full !== 1'b1) $display("FAIL fd_afull_448: got %b expected 1", almost_full); else n_pass++;
      end
    end
    n_total++; if (full !== 1'b1) $display("FAIL fd_full: got %b expected 1", full); else n_pass++;
    n_total++; if (count !== 10'd512) $display("FAIL fd_count_512: got %0d expected 512", count); else n_pass++;
    step(1, 8'hEE, 0, 0);
    n_total++; if (count !== 10'd512) $display("FAIL fd_count_513th: got %0d expected 512", count); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL fd_overflow: got %b expected 1", overflow); else n_pass++;
    for (int i = 0; i < 512; i++) begin
      step(0, 8'h00, 1, 0);
      if (i == 446) begin
        n_total++; if (almost_empty !== 1'b0) $display("FAIL fd_aempty_65: got %b expected 0", almost_empty); else n_pass++;
      end
      if (i == 447) begin
        n_total++; if (almost_empty !== 1'b1) $display("FAIL fd_aempty_64: got %b expected 1", almost_empty); else n_pass++;
      end
    end
    step(0, 8'h00, 0, 0);
    n_total++; if (empty !== 1'b1) $display("FAIL fd_empty: got %b expected 1", empty); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL fd_outstanding: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    step(0, 8'h00, 0, 1);
    n_total++; if (overflow !== 1'b0) $display("FAIL fpp_flush_ovf: got %b expected 0", overflow); else n_pass++;
    for (int i = 0; i < 512; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hAA, 1, 0);
    n_total++; if (count !== 10'd512) $display("FAIL fpp_count: got %0d expected 512", count); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL fpp_full: got %b expected 1", full); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL fpp_overflow: got %b expected 0", overflow); else n_pass++;
    for (int i = 0; i < 512; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    n_total++; if (count !== 10'd0) $display("FAIL fpp_drained: got %0d expected 0", count); else n_pass++;
  endtask

  task automatic test_empty_pop_push();
    step(1, 8'h55, 1, 0);
    n_total++; if (underflow !== 1'b1) $display("FAIL epp_underflow: got %b expected 1", underflow); else n_pass++;
    n_total++; if (count !== 10'd1) $display("FAIL epp_count: got %0d expected 1", count); else n_pass++;
    n_total++; if (pop_valid !== 1'b0) $display("FAIL epp_pop_valid: got %b expected 0", pop_valid); else n_pass++;
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    n_total++; if (count !== 10'd0) $display("FAIL epp_count_after: got %0d expected 0", count); else n_pass++;
  endtask

  task automatic test_wrap_flush();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 600; i++) step(1, 8'(i * 7 + 3), 1, 0);
    n_total++; if (count !== 10'd4) $display("FAIL wf_count_steady: got %0d expected 4", count); else n_pass++;
    push = 1'b0; pop = 1'b1; flush = 1'b1;
    #1;
    n_total++; if (mem_reb !== 1'b0) $display("FAIL wf_flush_reb: got %b expected 0", mem_reb); else n_pass++;
    step(0, 8'h00, 1, 1);
    n_total++; if (count !== 10'd0) $display("FAIL wf_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (pop_valid !== 1'b0) $display("FAIL wf_pop_valid: got %b expected 0", pop_valid); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL wf_empty: got %b expected 1", empty); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL wf_overflow: got %b expected 0", overflow); else n_pass++;
    n_total++; if (underflow !== 1'b0) $display("FAIL wf_underflow: got %b expected 0", underflow); else n_pass++;
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    n_total++; if (count !== 10'd0) $display("FAIL wf_post_flush: got %0d expected 0", count); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_fill_drain();
    test_full_push_pop();
    test_empty_pop_push();
    test_wrap_flush();
    n_total++; if (exp_q.size() != 0) $display("FAIL final_outstanding: got %0d expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
